dmem_arbiter: RTL and testbench

Shares the single data memory between the core's MEM stage and an external DMA/debug requester. It sits between the MEM stage, the DMA port and the data memory, and drives the memory's read address, write address, write data and write enable. The core has priority. A starvation counter forces a DMA slot, stalling the core for one cycle, when DMA has waited too long. Read data returns one cycle after the address (synchronous memory read); the arbiter tags DMA read returns with a valid strobe.

---
 rtl/dmem_arbiter.sv | 70 +++++++
 tb/tb_dmem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the core MEM stage and a DMA/debug port.
// The core has priority. A starvation counter forces a one-cycle DMA slot.
module dmem_arbiter #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int STARVE_LIMIT    = 4,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_core_access,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_core_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_core_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_core_wr_word,
    input  logic                       in_core_write_en,
    output logic                       out_core_stall,
    output logic [DMEM_WORD_WIDTH-1:0] out_core_rd_word,
    input  logic                       in_dma_req,
    input  logic                       in_dma_write,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dma_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dma_wr_word,
    output logic                       out_dma_gnt,
    output logic                       out_dma_rd_valid,
    output logic [DMEM_WORD_WIDTH-1:0] out_dma_rd_word,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
    output logic                       out_mem_write_en,
    input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word
);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] starve_cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 force_slot;
    logic                 rd_pending;
    logic                 dma_gnt;

    // grant/stall decision and memory port mux, all zero-latency
    always_comb begin
        dma_gnt          = in_dma_req & (~in_core_access | force_slot);
        out_dma_gnt      = dma_gnt;
        out_core_stall   = in_core_access & in_dma_req & force_slot;
        out_mem_rd_addr  = dma_gnt ? in_dma_addr : in_core_rd_addr;
        out_mem_wr_addr  = dma_gnt ? in_dma_addr : in_core_wr_addr;
        out_mem_wr_word  = dma_gnt ? in_dma_wr_word : in_core_wr_word;
        out_mem_write_en = dma_gnt ? in_dma_write : (in_core_access & in_core_write_en);
        out_core_rd_word = in_mem_rd_word;
        out_dma_rd_word  = in_mem_rd_word;
        out_dma_rd_valid = rd_pending;
    end

    // saturating count of consecutive denied DMA cycles; any grant or idle cycle clears it
    always_comb begin
        cnt_next = (in_dma_req & ~dma_gnt) ? ((starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1) : '0;
    end

    // force is raised on the same edge the counter reaches the limit, so the slot opens next cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            force_slot <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            starve_cnt <= cnt_next;
            force_slot <= (cnt_next == LIMIT);
            rd_pending <= dma_gnt & ~in_dma_write;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural synchronous memory.
module tb_dmem_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        core_access = 1'b0;
    logic [11:0] core_rd_addr = '0;
    logic [11:0] core_wr_addr = '0;
    logic [15:0] core_wr_word = '0;
    logic        core_write_en = 1'b0;
    logic        core_stall;
    logic [15:0] core_rd_word;
    logic        dma_req = 1'b0;
    logic        dma_write = 1'b0;
    logic [11:0] dma_addr = '0;
    logic [15:0] dma_wr_word = '0;
    logic        dma_gnt;
    logic        dma_rd_valid;
    logic [15:0] dma_rd_word;
    logic [11:0] mem_rd_addr;
    logic [11:0] mem_wr_addr;
    logic [15:0] mem_wr_word;
    logic        mem_write_en;
    logic [15:0] mem_rd_word;
    logic [15:0] mem [0:4095];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .in_core_access(core_access), .in_core_rd_addr(core_rd_addr),
        .in_core_wr_addr(core_wr_addr), .in_core_wr_word(core_wr_word),
        .in_core_write_en(core_write_en), .out_core_stall(core_stall),
        .out_core_rd_word(core_rd_word), .in_dma_req(dma_req),
        .in_dma_write(dma_write), .in_dma_addr(dma_addr),
        .in_dma_wr_word(dma_wr_word), .out_dma_gnt(dma_gnt),
        .out_dma_rd_valid(dma_rd_valid), .out_dma_rd_word(dma_rd_word),
        .out_mem_rd_addr(mem_rd_addr), .out_mem_wr_addr(mem_wr_addr),
        .out_mem_wr_word(mem_wr_word), .out_mem_write_en(mem_write_en),
        .in_mem_rd_word(mem_rd_word)
    );

    always #5 clock = ~clock;

    // synchronous-read data memory
    always @(posedge clock) begin
        if (mem_write_en) mem[mem_wr_addr] <= mem_wr_word;
        mem_rd_word <= mem[mem_rd_addr];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all;
        core_access = 1'b0; core_write_en = 1'b0; dma_req = 1'b0; dma_write = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; idle_all(); dma_req = 1'b1;
        #1;
        total_cnt++; if (dma_gnt !== 1'b1) $display("FAIL reset_gnt got %b want 1", dma_gnt); else pass_cnt++;
        total_cnt++; if (dma_rd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dma_rd_valid); else pass_cnt++;
        total_cnt++; if (core_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", core_stall); else pass_cnt++;
        tick(); tick();
        idle_all();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_dma_read;
        dma_req = 1'b1; dma_write = 1'b1; dma_addr = 12'h010; dma_wr_word = 16'hBEEF;
        #1;
        total_cnt++; if (mem_write_en !== 1'b1 || mem_wr_addr !== 12'h010) $display("FAIL preload_wr we=%b addr=%h want 1/010", mem_write_en, mem_wr_addr); else pass_cnt++;
        tick();
        dma_write = 1'b0;
        #1;
        total_cnt++; if (dma_gnt !== 1'b1) $display("FAIL read_gnt got %b want 1", dma_gnt); else pass_cnt++;
        total_cnt++; if (mem_rd_addr !== 12'h010 || mem_write_en !== 1'b0) $display("FAIL read_mem addr=%h we=%b want 010/0", mem_rd_addr, mem_write_en); else pass_cnt++;
        tick();
        dma_req = 1'b0;
        #1;
        total_cnt++; if (dma_rd_valid !== 1'b1 || dma_rd_word !== 16'hBEEF) $display("FAIL read_data valid=%b word=%h want 1/BEEF", dma_rd_valid, dma_rd_word); else pass_cnt++;
        tick();
        total_cnt++; if (dma_rd_valid !== 1'b0) $display("FAIL read_valid_drop got %b want 0", dma_rd_valid); else pass_cnt++;
    endtask

    task automatic test_starvation;
        core_access = 1'b1; core_write_en = 1'b1; core_wr_addr = 12'h022; core_wr_word = 16'h5678; core_rd_addr = 12'h022;
        dma_req = 1'b1; dma_write = 1'b1; dma_addr = 12'h020; dma_wr_word = 16'h1234;
        for (int c = 1; c <= 4; c++) begin
            #1;
            total_cnt++; if (dma_gnt !== 1'b0 || core_stall !== 1'b0 || mem_wr_addr !== 12'h022 || mem_write_en !== 1'b1)
                $display("FAIL starve_wait%0d gnt=%b stall=%b addr=%h we=%b want 0/0/022/1", c, dma_gnt, core_stall, mem_wr_addr, mem_write_en);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (dma_gnt !== 1'b1 || core_stall !== 1'b1) $display("FAIL starve_force gnt=%b stall=%b want 1/1", dma_gnt, core_stall); else pass_cnt++;
        total_cnt++; if (mem_wr_addr !== 12'h020 || mem_wr_word !== 16'h1234 || mem_write_en !== 1'b1)
            $display("FAIL starve_mem addr=%h word=%h we=%b want 020/1234/1", mem_wr_addr, mem_wr_word, mem_write_en);
        else pass_cnt++;
        tick();
        dma_req = 1'b0;
        #1;
        total_cnt++; if (dma_gnt !== 1'b0 || core_stall !== 1'b0 || mem_wr_addr !== 12'h022 || mem_wr_word !== 16'h5678)
            $display("FAIL starve_core_resume gnt=%b stall=%b addr=%h word=%h want 0/0/022/5678", dma_gnt, core_stall, mem_wr_addr, mem_wr_word);
        else pass_cnt++;
        tick();
        core_write_en = 1'b0; core_rd_addr = 12'h020;
        tick();
        core_rd_addr = 12'h022;
        total_cnt++; if (core_rd_word !== 16'h1234) $display("FAIL readback_dma got %h want 1234", core_rd_word); else pass_cnt++;
        tick();
        total_cnt++; if (core_rd_word !== 16'h5678) $display("FAIL readback_core got %h want 5678", core_rd_word); else pass_cnt++;
        idle_all();
        tick();
    endtask

    task automatic test_core_priority;
        core_access = 1'b1; core_write_en = 1'b0; core_rd_addr = 12'h030;
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 12'h040;
        #1;
        total_cnt++; if (mem_rd_addr !== 12'h030 || dma_gnt !== 1'b0 || core_stall !== 1'b0 || mem_write_en !== 1'b0)
            $display("FAIL priority addr=%h gnt=%b stall=%b we=%b want 030/0/0/0", mem_rd_addr, dma_gnt, core_stall, mem_write_en);
        else pass_cnt++;
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_withdraw;
        core_access = 1'b1; core_rd_addr = 12'h030; dma_write = 1'b0; dma_addr = 12'h010;
        dma_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++; if (dma_gnt !== 1'b0) $display("FAIL withdraw_pre%0d gnt=%b want 0", c, dma_gnt); else pass_cnt++;
            tick();
        end
        dma_req = 1'b0;
        #1;
        total_cnt++; if (dma_gnt !== 1'b0) $display("FAIL withdraw_drop gnt=%b want 0", dma_gnt); else pass_cnt++;
        tick();
        dma_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            total_cnt++; if (dma_gnt !== 1'b0 || core_stall !== 1'b0) $display("FAIL withdraw_re%0d gnt=%b stall=%b want 0/0", c, dma_gnt, core_stall); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (dma_gnt !== 1'b1 || core_stall !== 1'b1) $display("FAIL withdraw_force gnt=%b stall=%b want 1/1", dma_gnt, core_stall); else pass_cnt++;
        tick();
        dma_req = 1'b0;
        #1;
        total_cnt++; if (dma_rd_valid !== 1'b1 || dma_rd_word !== 16'hBEEF || core_stall !== 1'b0)
            $display("FAIL withdraw_rd valid=%b word=%h stall=%b want 1/BEEF/0", dma_rd_valid, dma_rd_word, core_stall);
        else pass_cnt++;
        idle_all();
        tick();
    endtask

    task automatic test_reset_mid_read;
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 12'h010;
        tick();
        dma_req = 1'b0;
        reset = 1'b0;
        #1;
        total_cnt++; if (dma_rd_valid !== 1'b0) $display("FAIL midreset_valid got %b want 0", dma_rd_valid); else pass_cnt++;
        tick();
        reset = 1'b1;
        tick();
        total_cnt++; if (dma_rd_valid !== 1'b0) $display("FAIL midreset_after got %b want 0", dma_rd_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals [3];
        vals[0] = 16'hA100; vals[1] = 16'hB202; vals[2] = 16'hC304;
        dma_req = 1'b1; dma_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dma_addr = 12'h050 + 12'(i); dma_wr_word = vals[i];
            #1;
            total_cnt++; if (dma_gnt !== 1'b1 || mem_write_en !== 1'b1) $display("FAIL b2b_wr%0d gnt=%b we=%b want 1/1", i, dma_gnt, mem_write_en); else pass_cnt++;
            tick();
        end
        dma_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dma_addr = 12'h050 + 12'(i);
            #1;
            total_cnt++; if (dma_gnt !== 1'b1) $display("FAIL b2b_rd_gnt%0d got %b want 1", i, dma_gnt); else pass_cnt++;
            total_cnt++; if (dma_rd_valid !== (i > 0)) $display("FAIL b2b_valid%0d got %b want %b", i, dma_rd_valid, i > 0); else pass_cnt++;
            if (i > 0) begin
                total_cnt++; if (dma_rd_word !== vals[i-1]) $display("FAIL b2b_word%0d got %h want %h", i, dma_rd_word, vals[i-1]); else pass_cnt++;
            end
            tick();
        end
        dma_req = 1'b0;
        #1;
        total_cnt++; if (dma_rd_valid !== 1'b1 || dma_rd_word !== vals[2]) $display("FAIL b2b_last valid=%b word=%h want 1/%h", dma_rd_valid, dma_rd_word, vals[2]); else pass_cnt++;
        tick();
        total_cnt++; if (dma_rd_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", dma_rd_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_dma_read();
        test_starvation();
        test_core_priority();
        test_withdraw();
        test_reset_mid_read();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
